bs_axis_packer: RTL
===================

# bs_axis_packer

Byte-to-AXI-Stream packer on the bitstream output of `h264_core`. It gathers the core's 8-bit `wdata_o`/`wvalid_o` byte stream into 64-bit beats and buffers them in a small FIFO, because the core cannot be back-pressured. Each frame goes out as one AXI4-Stream packet, with `tkeep` on the final partial beat and `tlast` marking frame end, ready for an S2MM DMA into SoC memory. It also reports the per-frame byte count and a sticky overflow flag to the RISC-V driver.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: beats buffered; power of two, ≥4.
- `AFULL_MARGIN`, 2: `wready_o` drops when free entries ≤ this value.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start_i` in 1: one-cycle pulse, the same as `sys_start`; opens a frame.
- `byte_valid_i` in 1: the core's `wvalid_o`.
- `byte_data_i` in 8: the core's `wdata_o`.
- `frame_done_i` in 1: marks the current byte as the last byte of the frame; only meaningful while `byte_valid_i`=1.
- `tdata_o` out 64: stream data; byte i is on `tdata_o[8*i+:8]`, first byte in lane 0.
- `tkeep_o` out 8: contiguous low-order lanes valid.
- `tvalid_o` out 1: a beat is available.
- `tlast_o` out 1: final beat of the frame.
- `tready_i` in 1: downstream accept.
- `wready_o` out 1: FIFO is not almost full; advisory only.
- `overflow_o` out 1: sticky; a beat was dropped.
- `frame_bytes_o` out 32: byte count of the last completed frame.
- `frame_end_o` out 1: one-cycle pulse when `frame_bytes_o` updates.

## Operation
- FSM has two states, `IDLE` and `ACTIVE`.
  - `IDLE` → `ACTIVE` on `frame_start_i`.
  - `ACTIVE` → `IDLE` on the cycle a byte is accepted with `frame_done_i`=1.
  - In `IDLE`, bytes and `frame_done_i` are ignored.
- On `frame_start_i`:
  - Clear `lane_cnt` (3 bits), the 56-bit accumulator, `byte_cnt` (32 bits) and `overflow_o`.
  - Any partial accumulator content is discarded.
  - FIFO contents are kept, because earlier frames may still be draining.
- On each accepted byte in `ACTIVE`:
  - Write it into lane `lane_cnt`.
  - `byte_cnt` increments, wrapping modulo 2^32.
- A push of {data, keep, last} into the FIFO occurs in the same cycle that:
  - `lane_cnt`=7, giving `keep`=8'hFF; or
  - `frame_done_i`=1, giving `keep`=(2^(lane_cnt+1))−1 and `last`=1.
  - If both hold, the beat is full with `last`=1.
  - After a push, `lane_cnt` returns to 0.
- At frame end:
  - `frame_bytes_o` ← `byte_cnt`+1, which includes the final byte.
  - `frame_end_o` pulses one cycle.
- FIFO full with no pop: the beat is dropped and `overflow_o` ← 1. The packer state still advances.
- Push and pop in the same cycle while full: the push succeeds and the count is unchanged.
- Output side is first-word-fall-through: `tvalid_o` = !empty, and {`tdata_o`, `tkeep_o`, `tlast_o`} = FIFO head.
- The FIFO pops on `tvalid_o && tready_i`.

## Timing
- Reset values of outputs:
  - `tvalid_o`=0, `tlast_o`=0, `tkeep_o`=0, `tdata_o`=0.
  - `wready_o`=1, `overflow_o`=0, `frame_bytes_o`=0, `frame_end_o`=0.
  - FSM enters `IDLE`.
- Latency: when the byte completing a beat arrives at edge k, `tvalid_o`=1 in the cycle after edge k+0. That is, the beat is visible one clock after the byte's valid cycle, provided the FIFO was empty.
- AXI rules:
  - Once `tvalid_o`=1, the beat is held stable until `tready_i`.
  - `tvalid_o` does not depend combinationally on `tready_i`.
- `frame_end_o` is asserted in the cycle after the final byte's valid cycle. It is registered together with the FIFO write.
- `wready_o` is registered and is 0 when free entries ≤ `AFULL_MARGIN`.
- `frame_start_i` together with a valid byte in the same cycle: the start takes priority and the byte is ignored.
- Reset mid-frame: all state and FIFO contents are lost immediately (asynchronous). No `tlast` is produced.

## Structure
- Shared package `bs_axis_pkg`:
  - `BEAT_W`=64, `KEEP_W`=8.
  - FIFO entry typedef {data[63:0], keep[7:0], last}, 73 bits.
  - FSM enum {`IDLE`, `ACTIVE`}.
- One natural sub-module: `bs_axis_fifo`.
  - Synchronous FWFT, 73 bits × `FIFO_DEPTH`.
  - Provides full, empty and a free-count output.
- Packer logic, counters and FSM live in the top `bs_axis_packer`.

## Test plan
- 16 bytes 0x00..0x0F in a frame, `frame_done_i` on 0x0F, `tready_i`=1:
  - Two beats: 64'h0706050403020100 and 64'h0F0E0D0C0B0A0908.
  - Both have `tkeep`=FF; the second has `tlast`=1.
  - `frame_bytes_o`=16.
- 11 bytes 0xA0..0xAA, done on 0xAA:
  - Beat 2 has `tkeep`=8'h07 and `tlast`=1, with lanes 0–2 = A8, A9, AA.
  - `frame_bytes_o`=11.
- Single byte 0x55 with `frame_done_i` in the same cycle:
  - One beat with `tkeep`=01, `tlast`=1, `tdata_o[7:0]`=55.
  - `frame_end_o` pulses once.
- `tready_i`=0 with 8·(`FIFO_DEPTH`+1) continuous bytes:
  - `wready_o` falls at free count = 2.
  - Exactly one beat is dropped and `overflow_o`=1.
  - After `tready_i`=1, the first `FIFO_DEPTH` beats drain in order, stable while stalled.
- Assert `rst_n`=0 after 5 bytes, then start a new frame of 8 bytes:
  - All outputs go to their reset values immediately.
  - The next packet holds only the new 8 bytes, `tlast`=1.
- `frame_start_i` pulse after 3 bytes of a frame:
  - The 3 bytes are discarded and `overflow_o` is cleared.
  - The following 8 bytes form the first beat, with `tkeep`=FF.

Source files
------------

// File: rtl/bs_axis_pkg.sv
// bs_axis_pkg: shared beat width, FIFO entry layout and FSM states for the byte-to-AXIS packer
package bs_axis_pkg;
  localparam int BEAT_W = 64;
  localparam int KEEP_W = 8;
  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;
  typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/bs_axis_fifo.sv
// bs_axis_fifo: FWFT beat FIFO (wr_en/wr_data in, rd_en/rd_data out, full/empty/free status); push while full succeeds only with a pop
module bs_axis_fifo
  import bs_axis_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  beat_t       wr_data,
  input  logic        rd_en,
  output beat_t       rd_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] free
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  beat_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic wr_ok, rd_ok;
  assign full    = cnt == DEPTH_C;
  assign empty   = cnt == '0;
  assign free    = DEPTH_C - cnt;
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ok ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd_ok ? rd_ptr + AW'(1) : rd_ptr;
      cnt    <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/bs_axis_packer.sv
// bs_axis_packer: packs h264 bitstream bytes (frame_start_i/byte_*/frame_done_i) into 64-bit AXIS beats (t*) with FIFO, wready_o, overflow_o and frame_bytes_o/frame_end_o
module bs_axis_packer
  import bs_axis_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  input  logic              frame_done_i,
  output logic [BEAT_W-1:0] tdata_o,
  output logic [KEEP_W-1:0] tkeep_o,
  output logic              tvalid_o,
  output logic              tlast_o,
  input  logic              tready_i,
  output logic              wready_o,
  output logic              overflow_o,
  output logic [31:0]       frame_bytes_o,
  output logic              frame_end_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] MARGIN = (AW+1)'(AFULL_MARGIN);
  state_t state, state_nxt;
  logic [2:0] lane_cnt;
  logic [55:0] acc;
  logic [31:0] byte_cnt;
  logic accept, last, push, pop, full, empty;
  logic [AW:0] free, free_nxt;
  logic [BEAT_W-1:0] beat_data;
  beat_t beat, head;
  assign accept    = state == ACTIVE && byte_valid_i && !frame_start_i;
  assign last      = accept && frame_done_i;
  assign push      = accept && (lane_cnt == 3'd7 || frame_done_i);
  assign pop       = tvalid_o && tready_i;
  // acc is zeroed after every push, so lanes above the current one are always 0
  assign beat_data = {8'h00, acc} | (BEAT_W'(byte_data_i) << {lane_cnt, 3'b000});
  assign beat      = {beat_data, 8'hFF >> (3'd7 - lane_cnt), frame_done_i};
  // wready_o tracks the free count after this edge, so it is exact rather than a cycle late
  assign free_nxt  = free - (AW+1)'(push && (!full || pop)) + (AW+1)'(pop);
  assign tvalid_o  = !empty;
  assign tdata_o   = head.data;
  assign tkeep_o   = head.keep;
  assign tlast_o   = head.last;
  bs_axis_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (push),
    .wr_data(beat),
    .rd_en  (pop),
    .rd_data(head),
    .full   (full),
    .empty  (empty),
    .free   (free)
  );
  always_comb begin
    state_nxt = frame_start_i ? ACTIVE : (last ? IDLE : state);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lane_cnt      <= '0;
      acc           <= '0;
      byte_cnt      <= '0;
      overflow_o    <= 1'b0;
      frame_bytes_o <= '0;
      frame_end_o   <= 1'b0;
      wready_o      <= 1'b1;
    end else begin
      state       <= state_nxt;
      frame_end_o <= last;
      wready_o    <= free_nxt > MARGIN;
      if (frame_start_i) begin
        lane_cnt   <= '0;
        acc        <= '0;
        byte_cnt   <= '0;
        overflow_o <= 1'b0;
      end else if (accept) begin
        byte_cnt   <= byte_cnt + 32'd1;
        lane_cnt   <= push ? 3'd0 : lane_cnt + 3'd1;
        acc        <= push ? '0 : beat_data[55:0];
        overflow_o <= overflow_o || (push && full && !pop);
      end
      if (last) frame_bytes_o <= byte_cnt + 32'd1;
    end
  end
endmodule
